pwm_bank: RTL and testbench

PWM_BANK -- requirements
Module: pwm_bank

---
 rtl/pwm_bank.sv | 151 +++++++++++++++
 tb/tb_pwm_bank.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_bank.sv
// Bank of NCH independent PWM channels behind a small register file.
// Period/duty writes land in staging registers and reach the counter only at a period boundary.
module pwm_bank #(
    parameter int NCH = 8,
    parameter int CW  = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           wr,
    input  logic           rd,
    input  logic [6:0]     adrs,
    input  logic [31:0]    din,
    output logic [31:0]    dout,
    output logic           rvalid,
    output logic [NCH-1:0] pwmo
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [1:0] R_CTRL   = 2'd0;
    localparam logic [1:0] R_PERIOD = 2'd1;
    localparam logic [1:0] R_DUTY   = 2'd2;
    localparam logic [1:0] R_STATUS = 2'd3;

    logic [2:0]  ch_sel;
    logic [1:0]  reg_sel;
    logic [31:0] chan_rdata [NCH];
    logic [31:0] rdata_next;
    logic        unused_ok;

    assign ch_sel    = adrs[6:4];
    assign reg_sel   = adrs[3:2];
    assign unused_ok = ^{adrs[1:0], din};

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            state_t        state_reg;
            logic          pol_reg;
            logic          flag_reg;
            logic [CW-1:0] per_stg_reg;
            logic [CW-1:0] duty_stg_reg;
            logic [CW-1:0] per_act_reg;
            logic [CW-1:0] duty_act_reg;
            logic [CW-1:0] cnt_reg;
            logic [CW-1:0] per_stg_next;
            logic [CW-1:0] duty_stg_next;
            logic          hit;
            logic          wr_ctrl;
            logic          wr_per;
            logic          wr_duty;
            logic          wr_stat;
            logic          disable_now;
            logic          wrap;
            logic [31:0]   rv;

            assign hit     = (ch_sel == 3'(gi));
            assign wr_ctrl = wr && hit && (reg_sel == R_CTRL);
            assign wr_per  = wr && hit && (reg_sel == R_PERIOD);
            assign wr_duty = wr && hit && (reg_sel == R_DUTY);
            assign wr_stat = wr && hit && (reg_sel == R_STATUS);

            // Reloads see a same-cycle staging write, so entry to RUN picks up fresh values.
            assign per_stg_next  = wr_per  ? din[CW-1:0] : per_stg_reg;
            assign duty_stg_next = wr_duty ? din[CW-1:0] : duty_stg_reg;

            assign disable_now = wr_ctrl && !din[0];
            assign wrap = (state_reg == RUN) && !disable_now && (per_act_reg != '0)
                          && (cnt_reg == per_act_reg - CW'(1));

            always_ff @(posedge clk) begin
                if (!rst) begin
                    state_reg    <= IDLE;
                    pol_reg      <= 1'b0;
                    flag_reg     <= 1'b0;
                    per_stg_reg  <= '0;
                    duty_stg_reg <= '0;
                    per_act_reg  <= '0;
                    duty_act_reg <= '0;
                    cnt_reg      <= '0;
                end else begin
                    per_stg_reg  <= per_stg_next;
                    duty_stg_reg <= duty_stg_next;
                    if (wr_ctrl) begin
                        pol_reg <= din[1];
                    end

                    if (state_reg == IDLE) begin
                        cnt_reg <= '0;
                        if (wr_ctrl && din[0]) begin
                            state_reg    <= RUN;
                            per_act_reg  <= per_stg_next;
                            duty_act_reg <= duty_stg_next;
                        end
                    end else if (disable_now) begin
                        state_reg <= IDLE;
                        cnt_reg   <= '0;
                    end else if (per_act_reg == '0 || wrap) begin
                        // A zero period parks the counter but keeps sampling staging.
                        cnt_reg      <= '0;
                        per_act_reg  <= per_stg_next;
                        duty_act_reg <= duty_stg_next;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end

                    if (wrap) begin
                        flag_reg <= 1'b1;
                    end else if (wr_stat && din[0]) begin
                        flag_reg <= 1'b0;
                    end
                end
            end

            assign pwmo[gi] = ((state_reg == RUN) && (per_act_reg != '0)
                               && (cnt_reg < duty_act_reg)) ^ pol_reg;

            always_comb begin
                rv = '0;
                case (reg_sel)
                    R_CTRL:   rv[1:0]    = {pol_reg, state_reg == RUN};
                    R_PERIOD: rv[CW-1:0] = per_stg_reg;
                    R_DUTY:   rv[CW-1:0] = duty_stg_reg;
                    default:  rv[0]      = flag_reg;
                endcase
            end

            assign chan_rdata[gi] = hit ? rv : '0;
        end
    endgenerate

    // Channels outside the bank never hit, so their reads fall out as zero.
    always_comb begin
        rdata_next = '0;
        for (int i = 0; i < NCH; i++) begin
            rdata_next = rdata_next | chan_rdata[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            dout   <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= rd;
            if (rd) begin
                dout <= rdata_next;
            end
        end
    end

endmodule

// File: tb/tb_pwm_bank.sv
// Bench for pwm_bank: cycle-level behavioural model on the default bank,
// literal waveform/readback checks, and a narrow CW=8/NCH=4 instance.
module tb_pwm_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr, rd;
    logic [6:0]  adrs;
    logic [31:0] din, dout;
    logic        rvalid;
    logic [7:0]  pwmo;

    logic        s_wr, s_rd;
    logic [6:0]  s_adrs;
    logic [31:0] s_din, s_dout;
    logic        s_rvalid;
    logic [3:0]  s_pwmo;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    pwm_bank dut (
        .clk(clk), .rst(rst), .wr(wr), .rd(rd), .adrs(adrs), .din(din),
        .dout(dout), .rvalid(rvalid), .pwmo(pwmo)
    );

    pwm_bank #(.NCH(4), .CW(8)) dut_s (
        .clk(clk), .rst(rst), .wr(s_wr), .rd(s_rd), .adrs(s_adrs), .din(s_din),
        .dout(s_dout), .rvalid(s_rvalid), .pwmo(s_pwmo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Behavioural model: each channel is a position within its current period.
    logic        m_run [8];
    logic        m_pol [8];
    logic        m_flag[8];
    logic [31:0] m_sper[8], m_sduty[8], m_aper[8], m_aduty[8], m_pos[8];
    logic [31:0] m_dout;
    logic        m_rvalid;

    function automatic logic [31:0] m_read(input logic [6:0] a);
        int c;
        c = int'(a[6:4]);
        case (a[3:2])
            2'd0:    return {30'd0, m_pol[c], m_run[c]};
            2'd1:    return m_sper[c];
            2'd2:    return m_sduty[c];
            default: return {31'd0, m_flag[c]};
        endcase
    endfunction

    function automatic logic [7:0] m_pwm();
        logic [7:0] e;
        for (int c = 0; c < 8; c++) begin
            e[c] = (m_run[c] && m_aper[c] != 0 && m_pos[c] < m_aduty[c]) ^ m_pol[c];
        end
        return e;
    endfunction

    always @(posedge clk) begin : model
        bit          hit, ctrl_w, wrapped;
        logic [31:0] sp, sd;
        if (!rst) begin
            for (int c = 0; c < 8; c++) begin
                m_run[c] = 0; m_pol[c] = 0; m_flag[c] = 0;
                m_sper[c] = 0; m_sduty[c] = 0; m_aper[c] = 0; m_aduty[c] = 0; m_pos[c] = 0;
            end
            m_dout   = 0;
            m_rvalid = 0;
        end else begin
            m_rvalid = rd;
            if (rd) m_dout = m_read(adrs);
            for (int c = 0; c < 8; c++) begin
                hit     = wr && (adrs[6:4] == 3'(c));
                ctrl_w  = hit && adrs[3:2] == 2'd0;
                sp      = (hit && adrs[3:2] == 2'd1) ? din : m_sper[c];
                sd      = (hit && adrs[3:2] == 2'd2) ? din : m_sduty[c];
                wrapped = 0;
                if (!m_run[c]) begin
                    if (ctrl_w && din[0]) begin
                        m_run[c] = 1; m_pos[c] = 0; m_aper[c] = sp; m_aduty[c] = sd;
                    end
                end else if (ctrl_w && !din[0]) begin
                    m_run[c] = 0; m_pos[c] = 0;
                end else if (m_aper[c] == 0 || m_pos[c] + 1 == m_aper[c]) begin
                    wrapped = (m_aper[c] != 0);
                    m_pos[c] = 0; m_aper[c] = sp; m_aduty[c] = sd;
                end else begin
                    m_pos[c] = m_pos[c] + 1;
                end
                if (wrapped) m_flag[c] = 1;
                else if (hit && adrs[3:2] == 2'd3 && din[0]) m_flag[c] = 0;
                if (ctrl_w) m_pol[c] = din[1];
                m_sper[c]  = sp;
                m_sduty[c] = sd;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("pwmo", 32'(pwmo), 32'(m_pwm()));
            check("rvalid", 32'(rvalid), 32'(m_rvalid));
            check("dout", dout, m_dout);
        end
    end

    task automatic do_write(input int ch, input int r, input logic [31:0] d);
        $display("write ch%0d reg%0d data=0x%08h", ch, r, d);
        wr = 1'b1; adrs = {3'(ch), 2'(r), 2'b00}; din = d;
        @(posedge clk); #1;
        wr = 1'b0;
    endtask

    task automatic rd_chk(input string name, input int ch, input int r, input logic [31:0] exp);
        rd = 1'b1; adrs = {3'(ch), 2'(r), 2'b00};
        @(posedge clk); #1;
        rd = 1'b0;
        $display("read  ch%0d reg%0d data=0x%08h rvalid=%0b", ch, r, dout, rvalid);
        check(name, dout, exp);
    endtask

    // Samples pwmo[ch] on n successive negedges; bit i of pat is sample i.
    task automatic record_check(input string name, input int ch, input int n, input logic [31:0] pat);
        logic [31:0] got = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            got[i] = pwmo[ch];
        end
        $display("wave  ch%0d %0d cycles bits=0x%08h", ch, n, got);
        check(name, got, pat);
    endtask

    task automatic s_access(input bit w, input int ch, input int r, input logic [31:0] d,
                            output logic [31:0] v, output logic rv);
        s_wr = w; s_rd = !w; s_adrs = {3'(ch), 2'(r), 2'b00}; s_din = d;
        @(posedge clk); #1;
        s_wr = 1'b0; s_rd = 1'b0;
        v = s_dout; rv = s_rvalid;
        $display("small %s ch%0d reg%0d data=0x%08h", w ? "write" : "read ", ch, r, w ? d : v);
    endtask

    initial begin
        logic [31:0] v;
        logic        rv;
        rst = 1'b0; wr = 1'b0; rd = 1'b0; adrs = '0; din = '0;
        s_wr = 1'b0; s_rd = 1'b0; s_adrs = '0; s_din = '0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        // Accesses while reset is low must be ignored.
        rd = 1'b1; wr = 1'b1; adrs = 7'h04; din = 32'h55;
        @(posedge clk); #1;
        rd = 1'b0; wr = 1'b0;
        check("rst_pwmo", 32'(pwmo), 32'h0);
        check("rst_rvalid", 32'(rvalid), 32'h0);
        check("rst_dout", dout, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        rd_chk("rst_ignored_wr", 0, 1, 32'h0);

        // Narrow instance: truncation and out-of-range channel.
        s_access(1'b1, 0, 1, 32'h1234, v, rv);
        s_access(1'b0, 0, 1, 32'h0, v, rv);
        check("s_trunc_period", v, 32'h34);
        check("s_rvalid0", 32'(rv), 32'h1);
        s_access(1'b1, 7, 1, 32'hFF, v, rv);
        s_access(1'b0, 7, 1, 32'h0, v, rv);
        check("s_ch7_read", v, 32'h0);
        check("s_rvalid7", 32'(rv), 32'h1);
        check("s_pwmo", 32'(s_pwmo), 32'h0);

        // Ch0: 3 high, 7 low, and the wrap flag.
        do_write(0, 1, 10);
        do_write(0, 2, 3);
        do_write(0, 0, 1);
        record_check("ch0_wave", 0, 20, 32'h0000_1C07);
        rd_chk("ch0_status", 0, 3, 32'h1);
        rd_chk("ch0_ctrl", 0, 0, 32'h1);

        // Same-cycle read and write returns the old value.
        rd = 1'b1; wr = 1'b1; adrs = {3'd0, 2'd1, 2'b00}; din = 32'd20;
        @(posedge clk); #1;
        rd = 1'b0; wr = 1'b0;
        check("rw_same_old", dout, 32'd10);
        rd_chk("rw_same_new", 0, 1, 32'd20);

        // Ch2: duty change mid-period waits for the boundary.
        do_write(2, 1, 8);
        do_write(2, 2, 2);
        do_write(2, 0, 1);
        fork
            record_check("ch2_glitchfree", 2, 24, 32'h003F_3F03);
            begin
                repeat (3) @(negedge clk);
                do_write(2, 2, 6);
            end
        join

        // Ch1: duty >= period, duty 0, then period 0.
        do_write(1, 1, 5);
        do_write(1, 2, 9);
        do_write(1, 0, 1);
        record_check("ch1_const_high", 1, 10, 32'h3FF);
        do_write(1, 2, 0);
        repeat (6) @(negedge clk);
        record_check("ch1_const_low", 1, 10, 32'h0);
        do_write(1, 1, 0);
        repeat (8) @(negedge clk);
        do_write(1, 3, 1);
        repeat (10) @(negedge clk);
        record_check("ch1_period0_low", 1, 5, 32'h0);
        rd_chk("ch1_status_stopped", 1, 3, 32'h0);

        // Ch4: clear coinciding with a wrap loses; a later clear wins.
        do_write(4, 1, 4);
        do_write(4, 2, 2);
        do_write(4, 0, 1);
        repeat (7) @(posedge clk);
        #1;
        do_write(4, 3, 1);
        rd_chk("ch4_wrap_priority", 4, 3, 32'h1);
        do_write(4, 3, 1);
        rd_chk("ch4_cleared", 4, 3, 32'h0);

        // Ch3: inverted polarity, then held at pol while idle.
        do_write(3, 1, 4);
        do_write(3, 2, 1);
        do_write(3, 0, 3);
        record_check("ch3_inverted", 3, 8, 32'hEE);
        do_write(3, 0, 2);
        record_check("ch3_idle_pol", 3, 4, 32'hF);

        // Reset mid-run clears everything.
        rst = 1'b0;
        @(posedge clk); #1;
        check("midrst_pwmo", 32'(pwmo), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        rd_chk("rst_ctrl3", 3, 0, 32'h0);
        rd_chk("rst_per0", 0, 1, 32'h0);
        rd_chk("rst_stat0", 0, 3, 32'h0);
        rd_chk("rst_stat4", 4, 3, 32'h0);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
